btn_evt_ctrl: RTL and testbench
===============================

# btn_evt_ctrl

Event controller and arbiter for the board's debounced push-buttons. Takes NUM_BTN debounced levels from the per-button debouncers. Runs one press/long-press/auto-repeat state machine per button, and merges all buttons into a single valid/ready event stream through a round-robin arbiter. Sits between the button debouncers and the game/menu control logic.

## Interface
- NUM_BTN, 4, number of buttons (≥2)
- LONG_CYC, 27_000_000, cycles a button must stay held before a long event (1 s @ 27 MHz)
- REPEAT_CYC, 5_400_000, cycles between repeat events while held (200 ms)

Ports:
- clk  in  1  clock
- n_reset  in  1  reset, synchronous, active-low
- btn_db  in  NUM_BTN  debounced levels, 1 = pressed
- evt_valid  out  1  event available
- evt_ready  in  1  consumer accepts event
- evt_id  out  IDW = max(1,$clog2(NUM_BTN))  button index
- evt_type  out  2  00 press, 01 release, 10 long, 11 repeat
- overflow  out  1  one-cycle pulse: an event was lost

## Operation
- **Edge detection.** btn_db is registered once into btn_q.
  - rise = btn_db & ~btn_q; fall = ~btn_db & btn_q.
- **Per-button FSM** (IDLE, PRESSED, HELD). Each FSM has one timer, width $clog2(max(LONG_CYC,REPEAT_CYC)).
  - IDLE: on rise, queue press, clear timer, go to PRESSED.
  - PRESSED: timer increments each cycle. When timer == LONG_CYC-1, queue long, clear timer, go to HELD. On fall, queue release, go to IDLE.
  - HELD: timer increments. When timer == REPEAT_CYC-1, queue repeat and clear timer. On fall, queue release, go to IDLE.
  - fall has priority over a same-cycle timer match.
- **Pending slot.** Each button has one pending slot (valid + type).
  - Queue into an empty slot, or into a slot being granted that cycle: accepted.
  - Queue into a slot holding a repeat: overwrites it, because repeat is lossy. No overflow.
  - Otherwise the new event is dropped and overflow pulses for 1 cycle.
- **Arbiter.** Round-robin over valid slots. The output register holds evt_valid/id/type.
  - The output register loads when it is empty, or when evt_valid & evt_ready.
  - The winner's slot clears in the same cycle it is loaded.
  - After granting button i, button i+1 (mod NUM_BTN) has highest priority.
- **Handshake.** Once evt_valid is high, evt_id/evt_type stay stable until evt_ready is sampled high.
- **Reset.** Clears btn_q, all FSMs (to IDLE), timers, slots and the RR pointer (to 0).
  - Outputs reset to: evt_valid 0, evt_id 0, evt_type 00, overflow 0.
  - Reset mid-operation discards all pending events.
  - A button held through reset produces a press event 2 cycles after n_reset deasserts.

## Timing
- btn_db change sampled at edge t: slot set at t+1, evt_valid high from t+2, if the output register is free and the slot wins arbitration.
- Sustained throughput with evt_ready=1: one event per cycle.
- A long event is queued LONG_CYC cycles after the press event is queued.
- Repeat events are queued every REPEAT_CYC cycles after that.
- overflow is asserted in the cycle after the dropped queue attempt.

## Configuration
- **BTN_EVT_REPEAT_EN defined:** auto-repeat behaves as above.
- **BTN_EVT_REPEAT_EN undefined:**
  - HELD only waits for fall; its timer is frozen.
  - evt_type 11 is never produced.
  - REPEAT_CYC is ignored, and the timer width uses LONG_CYC only.

## Structure
- **Package btn_evt_pkg:**
  - evt_type_t enum: EVT_PRESS=2'b00, EVT_RELEASE=2'b01, EVT_LONG=2'b10, EVT_REPEAT=2'b11.
  - btn_state_t enum: IDLE, PRESSED, HELD.
- **Sub-module btn_evt_fsm:** one button's edge detection, FSM, timer and pending slot. Instantiated NUM_BTN times in a generate loop.
- **Top level:** the arbiter and output register.

## Test plan
Bench parameters: NUM_BTN=4, LONG_CYC=100, REPEAT_CYC=20, macro defined unless noted.
1. btn_db[2] rises at edge 10 and falls at edge 50, evt_ready=1 → press id2 valid at cycle 12; release id2 valid at cycle 52; nothing else.
2. btn_db[0] held 165 cycles → press, long 100 cycles later, repeats at +120/+140/+160, then release. Exactly 6 events.
3. btn_db=4'b1111 in one cycle, evt_ready=1 → press events id 0,1,2,3 on 4 consecutive cycles. Then all four released at once → release ids 0,1,2,3 in RR order.
4. evt_ready=0: press btn1, release btn1, press btn1 again → output register holds press id1; slot holds release; the second press is dropped with overflow pulsing once. Then evt_ready=1 → press, release delivered.
5. btn3 held, reset asserted for 3 cycles mid-HELD with an event pending → all outputs 0 during reset; no stale event afterwards; press id3 appears 2 cycles after reset release.
6. Macro undefined, btn0 held 300 cycles → only press, long, release observed; evt_type 11 never seen.

Source files
------------

// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the push-button event controller.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        EVT_PRESS   = 2'b00,
        EVT_RELEASE = 2'b01,
        EVT_LONG    = 2'b10,
        EVT_REPEAT  = 2'b11
    } evt_type_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PRESSED = 2'b01,
        HELD    = 2'b10
    } btn_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Bit width able to hold 0..v-1, never narrower than one bit.
    function automatic int width_of(input int v);
        return (v > 2) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/btn_evt_fsm.sv
// One button: edge detection, press/long/repeat FSM, hold timer and
// single-entry pending slot. Auto-repeat is compiled in only when
// BTN_EVT_REPEAT_EN is defined.
//
// state   | meaning
// IDLE    | button released, waiting for a rising edge
// PRESSED | pressed, counting towards the long-press threshold
// HELD    | long press reported, emitting repeats (if enabled) until release
module btn_evt_fsm
    import btn_evt_pkg::*;
#(
    parameter int LONG_CYC   = 27_000_000,
    parameter int REPEAT_CYC = 5_400_000
) (
    input  logic      clk,
    input  logic      n_reset,
    input  logic      btn_db_i,
    input  logic      grant_i,
    output logic      slot_valid_o,
    output evt_type_t slot_type_o,
    output logic      overflow_o
);

`ifdef BTN_EVT_REPEAT_EN
    localparam int TMAX = max_int(LONG_CYC, REPEAT_CYC);
`else
    localparam int TMAX = LONG_CYC;
`endif
    localparam int TW = width_of(TMAX);
    localparam logic [TW-1:0] LONG_TC = TW'(LONG_CYC - 1);
`ifdef BTN_EVT_REPEAT_EN
    localparam logic [TW-1:0] REP_TC = TW'(REPEAT_CYC - 1);
`endif

    logic       btn_q;
    logic       rise, fall;
    btn_state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic       queue_en;
    evt_type_t  queue_type;
    logic       slot_valid_q, slot_valid_d;
    evt_type_t  slot_type_q, slot_type_d;
    logic       overflow_q, overflow_d;

    assign rise = btn_db_i & ~btn_q;
    assign fall = ~btn_db_i & btn_q;

    // Next state, timer and event to queue; a release beats a timer match.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        queue_en   = 1'b0;
        queue_type = EVT_PRESS;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    queue_en   = 1'b1;
                    queue_type = EVT_PRESS;
                    timer_d    = '0;
                    state_d    = PRESSED;
                end
            end
            PRESSED: begin
                if (fall) begin
                    queue_en   = 1'b1;
                    queue_type = EVT_RELEASE;
                    state_d    = IDLE;
                end else if (timer_q == LONG_TC) begin
                    queue_en   = 1'b1;
                    queue_type = EVT_LONG;
                    timer_d    = '0;
                    state_d    = HELD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HELD: begin
                if (fall) begin
                    queue_en   = 1'b1;
                    queue_type = EVT_RELEASE;
                    state_d    = IDLE;
`ifdef BTN_EVT_REPEAT_EN
                end else if (timer_q == REP_TC) begin
                    queue_en   = 1'b1;
                    queue_type = EVT_REPEAT;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending slot: accept when free, being granted, or holding a lossy repeat.
    always_comb begin
        slot_valid_d = slot_valid_q & ~grant_i;
        slot_type_d  = slot_type_q;
        overflow_d   = 1'b0;
        if (queue_en) begin
            if (!slot_valid_q || grant_i || slot_type_q == EVT_REPEAT) begin
                slot_valid_d = 1'b1;
                slot_type_d  = queue_type;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    // State, timer, slot and overflow registers.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            btn_q        <= 1'b0;
            state_q      <= IDLE;
            timer_q      <= '0;
            slot_valid_q <= 1'b0;
            slot_type_q  <= EVT_PRESS;
            overflow_q   <= 1'b0;
        end else begin
            btn_q        <= btn_db_i;
            state_q      <= state_d;
            timer_q      <= timer_d;
            slot_valid_q <= slot_valid_d;
            slot_type_q  <= slot_type_d;
            overflow_q   <= overflow_d;
        end
    end

    assign slot_valid_o = slot_valid_q;
    assign slot_type_o  = slot_type_q;
    assign overflow_o   = overflow_q;

endmodule

// File: rtl/btn_evt_ctrl.sv
// Button event controller: per-button FSMs merged into one valid/ready
// stream by a round-robin arbiter. Define BTN_EVT_REPEAT_EN for auto-repeat.
module btn_evt_ctrl
    import btn_evt_pkg::*;
#(
    parameter int NUM_BTN    = 4,
    parameter int LONG_CYC   = 27_000_000,
    parameter int REPEAT_CYC = 5_400_000,
    localparam int IDW       = width_of(NUM_BTN)
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [NUM_BTN-1:0] btn_db,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [IDW-1:0]     evt_id,
    output logic [1:0]         evt_type,
    output logic               overflow
);

    logic [NUM_BTN-1:0] slot_valid;
    evt_type_t          slot_type [NUM_BTN];
    logic [NUM_BTN-1:0] ovf_vec;
    logic [NUM_BTN-1:0] grant;

    logic           found;
    logic [IDW-1:0] win_id;
    evt_type_t      win_type;
    logic           load;

    logic           evt_valid_q, evt_valid_d;
    logic [IDW-1:0] evt_id_q, evt_id_d;
    evt_type_t      evt_type_q, evt_type_d;
    logic [IDW-1:0] rr_q, rr_d;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_evt_fsm #(
            .LONG_CYC   (LONG_CYC),
            .REPEAT_CYC (REPEAT_CYC)
        ) u_fsm (
            .clk          (clk),
            .n_reset      (n_reset),
            .btn_db_i     (btn_db[g]),
            .grant_i      (grant[g]),
            .slot_valid_o (slot_valid[g]),
            .slot_type_o  (slot_type[g]),
            .overflow_o   (ovf_vec[g])
        );
    end

    // Round-robin search for the first valid slot starting at rr_q.
    always_comb begin
        int idx;
        idx      = 0;
        found    = 1'b0;
        win_id   = '0;
        win_type = EVT_PRESS;
        for (int k = 0; k < NUM_BTN; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= NUM_BTN) idx = idx - NUM_BTN;
            if (!found && slot_valid[idx]) begin
                found    = 1'b1;
                win_id   = IDW'(idx);
                win_type = slot_type[idx];
            end
        end
    end

    assign load  = ~evt_valid_q | evt_ready;
    assign grant = (load && found) ? (NUM_BTN'(1) << win_id) : '0;

    // Output register and pointer update; id/type only move on a load.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        evt_type_d  = evt_type_q;
        rr_d        = rr_q;
        if (load) begin
            evt_valid_d = found;
            if (found) begin
                evt_id_d   = win_id;
                evt_type_d = win_type;
                rr_d       = (win_id == IDW'(NUM_BTN - 1)) ? '0 : win_id + 1'b1;
            end
        end
    end

    // Output and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            evt_type_q  <= EVT_PRESS;
            rr_q        <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            evt_type_q  <= evt_type_d;
            rr_q        <= rr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign evt_type  = evt_type_q;
    assign overflow  = |ovf_vec;

endmodule

// File: tb/tb_btn_evt_ctrl.sv
// Directed bench for btn_evt_ctrl with NUM_BTN=4, LONG_CYC=100, REPEAT_CYC=20.
module tb_btn_evt_ctrl;

    localparam int NB = 4;
    localparam int LC = 100;
    localparam int RC = 20;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic [NB-1:0] btn_db = '0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [1:0]    evt_id;
    logic [1:0]    evt_type;
    logic          overflow;

    always #5 clk = ~clk;

    btn_evt_ctrl #(
        .NUM_BTN    (NB),
        .LONG_CYC   (LC),
        .REPEAT_CYC (RC)
    ) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .btn_db    (btn_db),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_type  (evt_type),
        .overflow  (overflow)
    );

    typedef struct {
        int c;
        int id;
        int ty;
    } evt_t;

    int   cyc = 0;
    evt_t evq[$];
    int   ovf_cnt = 0;
    int   rep_seen = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted event with the cycle it was accepted in.
    always @(negedge clk) begin
        if (n_reset && evt_valid && evt_ready)
            evq.push_back('{cyc, int'(evt_id), int'(evt_type)});
        if (overflow) ovf_cnt++;
        if (evt_valid && evt_type == 2'b11) rep_seen++;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_evt(input string tag, input int k, input int c, input int id, input int ty);
        if (k < evq.size()) begin
            chk({tag, ".cyc"}, evq[k].c, c);
            chk({tag, ".id"}, evq[k].id, id);
            chk({tag, ".type"}, evq[k].ty, ty);
        end else begin
            chk({tag, ".missing"}, evq.size(), k + 1);
        end
    endtask

    initial begin
        int base, ob, d, r;

        // Reset values
        tick(3);
        chk("rst.valid", int'(evt_valid), 0);
        chk("rst.id", int'(evt_id), 0);
        chk("rst.type", int'(evt_type), 0);
        chk("rst.ovf", int'(overflow), 0);
        n_reset = 1'b1;
        tick(2);

        // All four pressed together, then all released together
        base = evq.size(); ob = ovf_cnt;
        evt_ready = 1'b1;
        d = cyc;
        btn_db = 4'b1111;
        tick(10);
        btn_db = 4'b0000;
        tick(10);
        for (int i = 0; i < 4; i++) chk_evt("all.press", base + i, d + 2 + i, i, 0);
        for (int i = 0; i < 4; i++) chk_evt("all.rel", base + 4 + i, d + 12 + i, i, 1);
        chk("all.count", evq.size() - base, 8);
        chk("all.ovf", ovf_cnt - ob, 0);

        // Single short press on button 2
        base = evq.size();
        d = cyc;
        btn_db[2] = 1'b1;
        tick(40);
        btn_db[2] = 1'b0;
        tick(10);
        chk_evt("b2.press", base, d + 2, 2, 0);
        chk_evt("b2.rel", base + 1, d + 42, 2, 1);
        chk("b2.count", evq.size() - base, 2);

        // Button 0 held: long press, then repeats if enabled
        base = evq.size();
        d = cyc;
        btn_db[0] = 1'b1;
`ifdef BTN_EVT_REPEAT_EN
        tick(165);
        btn_db[0] = 1'b0;
        tick(10);
        chk_evt("hold.press", base, d + 2, 0, 0);
        chk_evt("hold.long", base + 1, d + 102, 0, 2);
        chk_evt("hold.rep1", base + 2, d + 122, 0, 3);
        chk_evt("hold.rep2", base + 3, d + 142, 0, 3);
        chk_evt("hold.rep3", base + 4, d + 162, 0, 3);
        chk_evt("hold.rel", base + 5, d + 167, 0, 1);
        chk("hold.count", evq.size() - base, 6);
`else
        tick(300);
        btn_db[0] = 1'b0;
        tick(10);
        chk_evt("hold.press", base, d + 2, 0, 0);
        chk_evt("hold.long", base + 1, d + 102, 0, 2);
        chk_evt("hold.rel", base + 2, d + 302, 0, 1);
        chk("hold.count", evq.size() - base, 3);
        chk("hold.norepeat", rep_seen, 0);
`endif

        // Backpressure: press, release, press again with consumer stalled
        evt_ready = 1'b0;
        base = evq.size(); ob = ovf_cnt;
        d = cyc;
        btn_db[1] = 1'b1;
        tick(5);
        btn_db[1] = 1'b0;
        tick(3);
        btn_db[1] = 1'b1;
        tick(4);
        chk("bp.valid", int'(evt_valid), 1);
        chk("bp.id", int'(evt_id), 1);
        chk("bp.type", int'(evt_type), 0);
        chk("bp.ovf", ovf_cnt - ob, 1);
        tick(3);
        evt_ready = 1'b1;
        tick(5);
        btn_db[1] = 1'b0;
        tick(5);
        chk_evt("bp.press", base, d + 15, 1, 0);
        chk_evt("bp.rel", base + 1, d + 16, 1, 1);
        chk_evt("bp.rel2", base + 2, d + 22, 1, 1);
        chk("bp.count", evq.size() - base, 3);

        // Reset while button 3 is held with events pending
        base = evq.size(); ob = ovf_cnt;
        d = cyc;
        btn_db[3] = 1'b1;
        tick(50);
        evt_ready = 1'b0;
        tick(74);
        chk("mr.valid", int'(evt_valid), 1);
        chk("mr.id", int'(evt_id), 3);
        chk("mr.type", int'(evt_type), 2);
        n_reset = 1'b0;
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("mr.rst.valid", int'(evt_valid), 0);
            chk("mr.rst.id", int'(evt_id), 0);
            chk("mr.rst.type", int'(evt_type), 0);
            chk("mr.rst.ovf", int'(overflow), 0);
        end
        n_reset = 1'b1;
        r = cyc;
        tick(12);
        btn_db[3] = 1'b0;
        tick(10);
        chk_evt("mr.press0", base, d + 2, 3, 0);
        chk_evt("mr.press1", base + 1, r + 2, 3, 0);
        chk_evt("mr.rel", base + 2, r + 14, 3, 1);
        chk("mr.count", evq.size() - base, 3);
        chk("mr.ovf", ovf_cnt - ob, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
